// File: rtl/spi_pkg.sv
// Shared SPI definitions: default frame width, FSM states and bit-counter sizing.
// Used by both the spi_module controller and the spi_target endpoint.
package spi_pkg;

  localparam int SPI_DATA_WIDTH  = 24;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

  // The counter must hold the value DATA_WIDTH itself, hence the extra bit.
  function automatic int spi_cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered one-cycle
// rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  localparam int PW = $clog2(STAGES + 2);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic [PW-1:0]     prime_cnt;
  logic              primed;

  // Strobes stay quiet until the whole chain and prev hold real pin samples,
  // so a pin already at the non-reset level after reset produces no edge.
  assign primed = (prime_cnt == PW'(STAGES + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain     <= {STAGES{RESET_VAL}};
      prev      <= RESET_VAL;
      prime_cnt <= '0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
      if (!primed) prime_cnt <= prime_cnt + 1'b1;
      rise  <= primed &  chain[STAGES-1] & ~prev;
      fall  <= primed & ~chain[STAGES-1] &  prev;
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target endpoint, MSB first, fixed DATA_WIDTH frames, with
// valid/ready rx delivery and a single-entry tx holding register.
module spi_target
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sck_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  overrun_o,
  output logic                  frame_err_o,
  output spi_state_e            dbg_state
);

  localparam int CNT_W = spi_cnt_width(DATA_WIDTH);

  // Handshake: a transfer happens on a clk edge where valid && ready; the
  // producer holds data stable while valid is high and ready is low.

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_s;

  spi_state_e             state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-2:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic                   hold_full;
  logic [DATA_WIDTH-1:0]  hold_data;
  logic                   tx_write;
  logic                   word_done;
  logic [DATA_WIDTH-1:0]  rx_word;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sck_i),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cs_n_i),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // mosi gets the same depth so it stays aligned with the sck strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign tx_ready_o = ~hold_full;
  assign tx_write   = tx_valid_i & tx_ready_o;
  assign miso_o     = (state == SHIFT) ? tx_shift[DATA_WIDTH-1] : 1'b0;
  assign miso_oe_o  = (state != IDLE);
  assign dbg_state  = state;

  assign word_done = (state == SHIFT) && !cs_rise && sck_rise &&
                     (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign rx_word   = {rx_shift, mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (tx_write) begin
        hold_full <= 1'b1;
        hold_data <= tx_data_i;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            rx_shift <= '0;
            // A write landing on this same edge found the register empty and
            // is kept for the following frame.
            if (hold_full) begin
              tx_shift  <= hold_data;
              hold_full <= 1'b0;
            end else begin
              tx_shift <= '0;
            end
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state       <= IDLE;
            frame_err_o <= 1'b1;
          end else begin
            if (sck_rise) begin
              rx_shift <= rx_word[DATA_WIDTH-2:0];
              bit_cnt  <= bit_cnt + 1'b1;
              if (word_done) state <= DONE;
            end
            if (sck_fall) tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
        DONE: begin
          if (cs_rise)       state       <= IDLE;
          else if (sck_rise) frame_err_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (word_done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o  <= rx_word;
          rx_valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: table-driven frames, randomized frames against a
// word-level model, and hand-written error/reset sequences.
module tb_spi_target;
  import spi_pkg::*;

  localparam int W    = 24;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sck_i = 1'b0;
  logic         cs_n_i = 1'b1;
  logic         mosi_i = 1'b0;
  logic         miso_o, miso_oe_o;
  logic [W-1:0] tx_data_i = '0;
  logic         tx_valid_i = 1'b0;
  logic         tx_ready_o;
  logic [W-1:0] rx_data_o;
  logic         rx_valid_o;
  logic         rx_ready_i = 1'b0;
  logic         overrun_o, frame_err_o;
  spi_state_e   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  int ferr_cnt = 0;
  int wide_cnt = 0;
  logic ovr_q  = 1'b0;
  logic ferr_q = 1'b0;

  // word-level model of the core-facing side
  logic         m_hold_full = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int           exp_ovr = 0;
  int           exp_ferr = 0;

  typedef struct {
    logic [W-1:0] mosi;
    logic [W-1:0] tx;
    logic         load;
    logic [W-1:0] exp_rx;
    logic [W-1:0] exp_miso;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  spi_target #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck_i      (sck_i),
    .cs_n_i     (cs_n_i),
    .mosi_i     (mosi_i),
    .miso_o     (miso_o),
    .miso_oe_o  (miso_oe_o),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .rx_ready_i (rx_ready_i),
    .overrun_o  (overrun_o),
    .frame_err_o(frame_err_o),
    .dbg_state  (dbg_state)
  );

  always @(posedge clk) begin
    #1;
    if (overrun_o) ovr_cnt++;
    if (frame_err_o) ferr_cnt++;
    if ((overrun_o && ovr_q) || (frame_err_o && ferr_q)) wide_cnt++;
    ovr_q  = overrun_o;
    ferr_q = frame_err_o;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_miso"}, miso_o, 1'b0);
    check_b({tag, "_miso_oe"}, miso_oe_o, 1'b0);
    check_b({tag, "_tx_ready"}, tx_ready_o, 1'b1);
    check_w({tag, "_rx_data"}, rx_data_o, '0);
    check_b({tag, "_rx_valid"}, rx_valid_o, 1'b0);
    check_b({tag, "_overrun"}, overrun_o, 1'b0);
    check_b({tag, "_frame_err"}, frame_err_o, 1'b0);
  endtask

  task automatic tx_write(input logic [W-1:0] d);
    int t;
    t = 0;
    while (!tx_ready_o && t < 200) begin
      tick(1);
      t++;
    end
    if (!tx_ready_o) check_b("tx_ready_wait", tx_ready_o, 1'b1);
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    tick(1);
    tx_valid_i = 1'b0;
    m_hold_full = 1'b1;
    m_hold      = d;
  endtask

  task automatic accept();
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
    tick(1);
    m_valid = 1'b0;
  endtask

  // Runs one controller frame; miso is sampled just before each sck rise.
  task automatic frame(input logic [W-1:0] mo, input int edges, input logic rdy_last,
                       output logic [W-1:0] mi, output logic rdy_low);
    mi = '0;
    rdy_low = 1'b0;
    cs_n_i = 1'b0;
    tick(HALF);
    for (int i = 0; i < edges; i++) begin
      mosi_i = (i < W) ? mo[W-1-i] : 1'b0;
      tick(HALF);
      if (i < W) mi = {mi[W-2:0], miso_o};
      if (!tx_ready_o) rdy_low = 1'b1;
      if (rdy_last && i == W - 1) rx_ready_i = 1'b1;
      sck_i = 1'b1;
      tick(HALF);
      sck_i = 1'b0;
    end
    tick(HALF);
    cs_n_i = 1'b1;
    rx_ready_i = 1'b0;
    tick(HALF);
  endtask

  // Model of one full frame completing with rx_ready_i low.
  task automatic model_complete(input logic [W-1:0] word);
    if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = word;
    end else begin
      exp_ovr++;
    end
  endtask

  initial begin
    logic [W-1:0] mi, word, exp_miso;
    logic         rdy_low;

    tbl[0] = '{24'h0000AB, 24'hC3A5F0, 1'b1, 24'h0000AB, 24'hC3A5F0};
    tbl[1] = '{24'hFFFFFF, 24'h000000, 1'b0, 24'hFFFFFF, 24'h000000};
    tbl[2] = '{24'h123456, 24'h5A5A5A, 1'b1, 24'h123456, 24'h5A5A5A};
    tbl[3] = '{24'h800001, 24'h7FFFFE, 1'b1, 24'h800001, 24'h7FFFFE};
    tbl[4] = '{24'h000000, 24'hFFFFFF, 1'b1, 24'h000000, 24'hFFFFFF};

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(10);

    for (int v = 0; v < 5; v++) begin
      if (tbl[v].load) begin
        tx_write(tbl[v].tx);
        check_b($sformatf("tbl%0d_tx_ready_drop", v), tx_ready_o, 1'b0);
      end
      frame(tbl[v].mosi, W, 1'b0, mi, rdy_low);
      m_hold_full = 1'b0;
      check_w($sformatf("tbl%0d_miso", v), mi, tbl[v].exp_miso);
      check_w($sformatf("tbl%0d_rx_data", v), rx_data_o, tbl[v].exp_rx);
      check_b($sformatf("tbl%0d_rx_valid", v), rx_valid_o, 1'b1);
      check_b($sformatf("tbl%0d_tx_ready_frame", v), rdy_low, 1'b0);
      tick(20);
      check_b($sformatf("tbl%0d_rx_valid_held", v), rx_valid_o, 1'b1);
      accept();
      check_b($sformatf("tbl%0d_rx_valid_clear", v), rx_valid_o, 1'b0);
      check_i($sformatf("tbl%0d_overrun", v), ovr_cnt, exp_ovr);
    end

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 1) == 1 && !m_hold_full) tx_write(W'($urandom));
      exp_miso = m_hold_full ? m_hold : '0;
      m_hold_full = 1'b0;
      word = W'($urandom);
      frame(word, W, 1'b0, mi, rdy_low);
      model_complete(word);
      check_w($sformatf("rand%0d_miso", r), mi, exp_miso);
      check_w($sformatf("rand%0d_rx_data", r), rx_data_o, m_data);
      check_b($sformatf("rand%0d_rx_valid", r), rx_valid_o, m_valid);
      check_i($sformatf("rand%0d_overrun", r), ovr_cnt, exp_ovr);
      if ($urandom_range(0, 2) != 0) accept();
    end
    if (m_valid) accept();

    frame(24'h123456, W, 1'b0, mi, rdy_low);
    model_complete(24'h123456);
    frame(24'h654321, W, 1'b0, mi, rdy_low);
    model_complete(24'h654321);
    check_w("ovr_keep_old", rx_data_o, 24'h123456);
    check_i("ovr_pulse", ovr_cnt, exp_ovr);
    accept();

    frame(24'h0A0A0A, W, 1'b0, mi, rdy_low);
    model_complete(24'h0A0A0A);
    frame(24'h654321, W, 1'b1, mi, rdy_low);
    m_valid = 1'b0;
    check_w("ready_last_rx_data", rx_data_o, 24'h654321);
    check_i("ready_last_no_ovr", ovr_cnt, exp_ovr);
    check_b("ready_last_valid", rx_valid_o, 1'b0);

    frame(24'h0F0F0F, 10, 1'b0, mi, rdy_low);
    exp_ferr++;
    check_i("abort_frame_err", ferr_cnt, exp_ferr);
    check_b("abort_rx_valid", rx_valid_o, 1'b0);
    frame(24'hFFFFFF, W, 1'b0, mi, rdy_low);
    check_w("after_abort_rx_data", rx_data_o, 24'hFFFFFF);
    check_b("after_abort_rx_valid", rx_valid_o, 1'b1);
    accept();

    frame(24'hA5C3E1, W + 1, 1'b0, mi, rdy_low);
    exp_ferr++;
    check_w("extra_edge_rx_data", rx_data_o, 24'hA5C3E1);
    check_b("extra_edge_rx_valid", rx_valid_o, 1'b1);
    check_i("extra_edge_frame_err", ferr_cnt, exp_ferr);
    check_i("extra_edge_no_ovr", ovr_cnt, exp_ovr);

    // Reset at bit 12 with cs held low, then keep clocking a whole frame.
    cs_n_i = 1'b0;
    tick(HALF);
    for (int i = 0; i < 12; i++) begin
      mosi_i = 1'($urandom);
      tick(HALF); sck_i = 1'b1; tick(HALF); sck_i = 1'b0;
    end
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_hold_full = 1'b0;
    for (int i = 0; i < W; i++) begin
      mosi_i = 1'($urandom);
      tick(HALF); sck_i = 1'b1; tick(HALF); sck_i = 1'b0;
    end
    tick(HALF);
    check_b("postreset_no_capture", rx_valid_o, 1'b0);
    check_b("postreset_idle_oe", miso_oe_o, 1'b0);
    check_i("postreset_no_ferr", ferr_cnt, exp_ferr);
    cs_n_i = 1'b1;
    tick(HALF);
    frame(24'h3C3C3C, W, 1'b0, mi, rdy_low);
    check_w("postreset_rx_data", rx_data_o, 24'h3C3C3C);
    check_b("postreset_rx_valid", rx_valid_o, 1'b1);
    accept();

    check_i("pulse_width", wide_cnt, 0);
    check_i("final_overrun", ovr_cnt, exp_ovr);
    check_i("final_frame_err", ferr_cnt, exp_ferr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_target.md
# spi_target

SPI target (slave) endpoint that terminates the link driven by the team's `spi_module` controller. It operates in mode 0 (CPOL=0, CPHA=0), MSB first, with fixed DATA_WIDTH-bit frames. SCK, CS_n and MOSI are oversampled in the local clk domain. Received words go to the core over a valid/ready port, and response words are accepted from the core over a second valid/ready port for return on MISO.

## Interface
- DATA_WIDTH, 24, bits per frame
- SYNC_STAGES, 2, synchronizer depth on sck_i/cs_n_i/mosi_i (≥2)
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- sck_i  in  1  SPI clock from controller, asynchronous to clk
- cs_n_i  in  1  chip select, active low, asynchronous
- mosi_i  in  1  controller-to-target data
- miso_o  out  1  target-to-controller data
- miso_oe_o  out  1  MISO output enable, 1 while selected
- tx_data_i  in  DATA_WIDTH  response word for next frame
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  holding register empty
- rx_data_o  out  DATA_WIDTH  last complete received word
- rx_valid_o  out  1  rx_data_o valid, held until accepted
- rx_ready_i  in  1  core accepts rx_data_o
- overrun_o  out  1  one-cycle pulse: completed word dropped
- frame_err_o  out  1  one-cycle pulse: CS_n rose mid-frame or extra SCK edge

## Operation
- Reset values: miso_o=0, miso_oe_o=0, tx_ready_o=1, rx_data_o=0, rx_valid_o=0, overrun_o=0, frame_err_o=0. Synchronizers reset to cs_n=1, sck=0, mosi=0. FSM resets to IDLE. Bit counter resets to 0.
- Edge detect: registered copy of the synchronized sck/cs_n. sck_rise, sck_fall and cs_fall/cs_rise are each one-cycle strobes.
- FSM states:
  - IDLE -> SHIFT on cs_fall. Load tx_shift from the holding register if it is full and clear the holding register; otherwise load all zeros. Clear the bit counter.
  - SHIFT: on sck_rise, rx_shift <= {rx_shift[W-2:0], mosi_s} and the counter increments. On sck_fall, tx_shift shifts left by 1. When the counter reaches DATA_WIDTH, go to DONE and deliver the word.
  - SHIFT -> IDLE on cs_rise with counter < DATA_WIDTH. Pulse frame_err_o and discard partial data.
  - DONE: wait for cs_rise, then go to IDLE. An sck_rise in DONE pulses frame_err_o and captures nothing; MISO is held at 0.
- miso_o = tx_shift[DATA_WIDTH-1] in SHIFT, 0 otherwise. miso_oe_o = 1 in SHIFT/DONE.
- Tx holding: a write occurs when tx_valid_i && tx_ready_o. tx_ready_o drops the next cycle and rises the cycle after the holding register is loaded into tx_shift. A write in the same cycle as cs_fall with the holding register empty is held for the next frame.
- Rx delivery on word completion:
  - If rx_valid_o=0, or rx_ready_i=1 in the same cycle: rx_data_o <= word, rx_valid_o=1.
  - Else keep the old word, drop the new one, and pulse overrun_o.
  - rx_valid_o clears on rx_valid_o && rx_ready_i when there is no simultaneous delivery.
- Reset mid-frame aborts the frame silently, with no error pulse. If cs_n_i is already low when reset releases, the block stays in IDLE until a fresh cs_fall.

## Timing
- Legal SCK high and low times are each ≥ SYNC_STAGES+2 clk periods. CS_n setup before the first SCK rise is ≥ SYNC_STAGES+2 clk.
- MISO bit 23 is driven SYNC_STAGES+2 clk after the CS_n fall pin edge. The next bit follows SYNC_STAGES+2 clk after each SCK fall.
- rx_valid_o rises SYNC_STAGES+2 clk after the 24th SCK rise at the pin.
- overrun_o and frame_err_o are exactly one clk wide.

## Structure
- Package `spi_pkg`: DATA_WIDTH default, FSM state enum (IDLE, SHIFT, DONE), and bit-counter width $clog2(DATA_WIDTH)+1. The package is shared with `spi_module`.
- Sub-module `spi_sync_edge`: SYNC_STAGES-flop synchronizer with a reset value parameter, plus rise/fall strobes. It is instantiated for sck and cs_n. mosi uses the synchronizer only, with the same depth so it stays aligned with sck.

## Test plan
- Back-to-back with `spi_module` (DATA_WIDTH=24), controller sends 24'h0000AB, tx_data_i=24'hC3A5F0 preloaded → rx_data_o=24'h0000AB, rx_valid_o held until rx_ready_i, and controller sdi_data_o=24'hC3A5F0.
- No tx write before the frame → MISO all zeros for 24 bits; tx_ready_o stays 1 throughout.
- Two frames (24'h123456, 24'h654321) with rx_ready_i=0 → rx_data_o=24'h123456, one overrun_o pulse at the second completion. Repeat with rx_ready_i=1 in the completion cycle → rx_data_o=24'h654321, no overrun.
- CS_n raised after 10 SCK edges → frame_err_o one pulse, rx_valid_o stays 0. The next full frame 24'hFFFFFF is received correctly.
- 25 SCK edges in one frame → word delivered after edge 24 and frame_err_o pulse on edge 25. rst_n asserted at bit 12 with cs_n held low → all outputs at reset values, and no capture until CS_n toggles high then low.
